// File: rtl/uart_report_pkg.sv
// Shared definitions for the counter UART reporter: TX FSM encoding, ASCII
// constants and the nibble-to-hex-digit helper.
package uart_report_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } tx_state_e;

  localparam logic [7:0] CR      = 8'h0D;
  localparam logic [7:0] LF      = 8'h0A;
  localparam logic [7:0] DIGIT0  = 8'h30;
  localparam logic [7:0] ALPHA_A = 8'h41;

  // Uppercase ASCII hex digit for a nibble.
  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    if (n < 4'd10) begin
      hex_ascii = DIGIT0 + {4'd0, n};
    end else begin
      hex_ascii = ALPHA_A + {4'd0, n} - 8'd10;
    end
  endfunction

endpackage

// File: rtl/uart_tx_core.sv
// 8N1 serial shifter with a byte/valid/ready handshake. ready is also high in
// the last cycle of the stop bit so a waiting byte starts with no idle gap.
module uart_tx_core
  import uart_report_pkg::*;
#(
  parameter int unsigned BAUD_DIV = 104
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_byte,
  input  logic       valid,
  output logic       ready,
  output logic       tx
);

  localparam logic [15:0] BitLast = 16'(BAUD_DIV - 1);

  tx_state_e   state_q;
  logic [15:0] baud_q;
  logic [2:0]  bit_q;
  logic [7:0]  shreg_q;
  logic        tx_q;
  logic        bit_end;

  assign bit_end = (baud_q == BitLast);
  assign ready   = (state_q == StIdle) || ((state_q == StStop) && bit_end);
  assign tx      = tx_q;

  // Frame sequencing: start bit, eight data bits LSB first, stop bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      baud_q  <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      tx_q    <= 1'b1;
    end else if (valid && ready) begin
      // New byte either from idle or chained straight off a finishing stop bit.
      state_q <= StStart;
      baud_q  <= '0;
      bit_q   <= '0;
      shreg_q <= tx_byte;
      tx_q    <= 1'b0;
    end else begin
      if (state_q != StIdle) begin
        baud_q <= bit_end ? 16'd0 : baud_q + 16'd1;
      end
      if (bit_end) begin
        unique case (state_q)
          StStart: begin
            state_q <= StData;
            bit_q   <= '0;
            tx_q    <= shreg_q[0];
          end
          StData: begin
            if (bit_q == 3'd7) begin
              state_q <= StStop;
              tx_q    <= 1'b1;
            end else begin
              bit_q   <= bit_q + 3'd1;
              shreg_q <= {1'b0, shreg_q[7:1]};
              tx_q    <= shreg_q[1];
            end
          end
          StStop: begin
            state_q <= StIdle;
            baud_q  <= '0;
            tx_q    <= 1'b1;
          end
          default: begin
            state_q <= StIdle;
            tx_q    <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/counter_uart_reporter.sv
// Reports an 8-bit sample as two uppercase hex digits plus CR LF over 8N1.
// Requests arriving mid-frame are dropped and flagged with a one-cycle pulse.
module counter_uart_reporter
  import uart_report_pkg::*;
#(
  parameter int unsigned BAUD_DIV = 104
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] data,
  input  logic       stb,
  output logic       busy,
  output logic       drop,
  output logic       tx
);

  logic [7:0] data_q;
  logic [1:0] idx_q;
  logic       busy_q;
  logic       drop_q;

  logic       accept;
  logic       core_ready;
  logic       core_valid;
  logic [7:0] core_byte;
  logic [7:0] next_char;

  assign accept = stb & ~busy_q;
  assign busy   = busy_q;
  assign drop   = drop_q;

  // Character following the one currently on the line.
  always_comb begin
    next_char = LF;
    unique case (idx_q)
      2'd0:    next_char = hex_ascii(data_q[3:0]);
      2'd1:    next_char = CR;
      default: next_char = LF;
    endcase
  end

  // First digit comes straight from the input so the start bit leaves next cycle.
  always_comb begin
    core_byte  = accept ? hex_ascii(data[7:4]) : next_char;
    core_valid = accept | (busy_q & (idx_q != 2'd3));
  end

  // Request acceptance, character index and drop flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      idx_q  <= '0;
      busy_q <= 1'b0;
      drop_q <= 1'b0;
    end else begin
      drop_q <= stb & busy_q;
      if (accept) begin
        data_q <= data;
        idx_q  <= '0;
        busy_q <= 1'b1;
      end else if (busy_q && core_ready) begin
        // core_ready during a frame marks the end of a stop bit.
        if (idx_q == 2'd3) begin
          busy_q <= 1'b0;
        end else begin
          idx_q <= idx_q + 2'd1;
        end
      end
    end
  end

  uart_tx_core #(
    .BAUD_DIV(BAUD_DIV)
  ) u_tx_core (
    .clk    (clk),
    .rst_n  (rst_n),
    .tx_byte(core_byte),
    .valid  (core_valid),
    .ready  (core_ready),
    .tx     (tx)
  );

endmodule

// File: tb/tb_counter_uart_reporter.sv
// Directed bench for counter_uart_reporter with BAUD_DIV=4.
module tb_counter_uart_reporter;

  localparam int B = 4;
  localparam int FRAME = 40 * B;

  logic       clk;
  logic       rst_n;
  logic [7:0] data;
  logic       stb;
  logic       busy;
  logic       drop;
  logic       tx;

  int total = 0;
  int bad   = 0;

  string hexs = "0123456789ABCDEF";

  counter_uart_reporter #(
    .BAUD_DIV(B)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .data (data),
    .stb  (stb),
    .busy (busy),
    .drop (drop),
    .tx   (tx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Called at a negedge; request is seen at the next rising edge.
  task automatic pulse_stb(input logic [7:0] d);
    stb  = 1'b1;
    data = d;
    @(negedge clk);
    stb  = 1'b0;
  endtask

  task automatic idle_check(input int n);
    for (int i = 0; i < n; i++) begin
      chk("idle_tx", tx, 1);
      chk("idle_busy", busy, 0);
      chk("idle_drop", drop, 0);
      @(negedge clk);
    end
  endtask

  // Starts at the negedge just after the accepting edge; c counts cycles from it.
  // inject: cycle at which a second STB is raised (-1 for none).
  task automatic run_frame(input logic [7:0] d, input int inject, input int ncyc);
    logic [7:0] expb[4];
    logic [9:0] sh;
    logic       drop_exp;
    int         ch;
    int         bitp;
    expb[0]  = hexs.getc(int'(d[7:4]));
    expb[1]  = hexs.getc(int'(d[3:0]));
    expb[2]  = 8'h0D;
    expb[3]  = 8'h0A;
    sh       = '0;
    drop_exp = 1'b0;
    for (int c = 0; c < ncyc; c++) begin
      ch   = c / (10 * B);
      bitp = (c / B) % 10;
      chk("busy", busy, 1);
      chk("drop", drop, drop_exp);
      drop_exp = (c == inject);
      stb      = (c == inject);
      if (c % (10 * B) == 0) chk("start_edge", tx, 0);
      if (c % B == B / 2) begin
        sh[bitp] = tx;
        if (bitp == 9) begin
          chk("start_bit", sh[0], 0);
          chk("stop_bit", sh[9], 1);
          chk("byte", sh[8:1], expb[ch]);
        end
      end
      @(negedge clk);
    end
    if (ncyc == FRAME) begin
      chk("end_busy", busy, 0);
      chk("end_tx", tx, 1);
      chk("end_drop", drop, drop_exp);
      stb = 1'b0;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    stb   = 1'b0;
    data  = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_tx", tx, 1);
    chk("rst_busy", busy, 0);
    chk("rst_drop", drop, 0);
    rst_n = 1'b1;
    @(negedge clk);
    idle_check(3);

    // Single frame 0xA5.
    pulse_stb(8'hA5);
    run_frame(8'hA5, -1, FRAME);
    @(negedge clk);
    idle_check(5);

    // Back-to-back frames: second request on the first BUSY=0 cycle.
    pulse_stb(8'h00);
    run_frame(8'h00, -1, FRAME);
    pulse_stb(8'hFF);
    run_frame(8'hFF, -1, FRAME);
    @(negedge clk);
    idle_check(5);

    // Request during third character is dropped; no follow-up frame.
    pulse_stb(8'h5A);
    run_frame(8'h5A, 20 * B + 5, FRAME);
    @(negedge clk);
    idle_check(50);

    // Request on the last stop-bit cycle is dropped.
    pulse_stb(8'h7E);
    run_frame(8'h7E, FRAME - 1, FRAME);
    @(negedge clk);
    idle_check(10);

    // Reset during data bits of the second character.
    pulse_stb(8'h12);
    run_frame(8'h12, -1, 13 * B + 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_tx", tx, 1);
    chk("midrst_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    idle_check(60);
    pulse_stb(8'h3C);
    run_frame(8'h3C, -1, FRAME);
    @(negedge clk);
    idle_check(3);

    // Sweep every sample value.
    for (int i = 0; i < 256; i++) begin
      pulse_stb(8'(i));
      run_frame(8'(i), -1, FRAME);
    end
    @(negedge clk);
    idle_check(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/counter_uart_reporter.md
# counter_uart_reporter

Downstream consumer of the LED counter value: accepts an 8-bit sample with a one-cycle strobe and transmits it over the board's serial line. The sample is sent as two uppercase ASCII hex digits followed by CR LF, using 8N1 framing. The block sits between the prescaled counter and the TX pin, so the count can be logged on the host.

## Interface
- BAUD_DIV, 104, CLK cycles per bit (12 MHz / 115200); legal range 2..65535
- CLK  in  1  system clock
- RSTN  in  1  asynchronous, active-low reset
- DATA  in  8  sample to report; sampled only on an accepted STB
- STB  in  1  single-cycle request to report DATA
- BUSY  out  1  frame in progress; STB is not accepted while high
- DROP  out  1  one-cycle pulse when STB arrives while BUSY is high
- TX  out  1  serial output, idle high

## Operation
- Reset (async assert, sync release) forces TX=1, BUSY=0, DROP=0, state IDLE, baud and bit counters to 0.
- Accepted request: STB=1 while BUSY=0.
  - Latch DATA.
  - Build a four-character queue: hex(DATA[7:4]), hex(DATA[3:0]), 0x0D, 0x0A.
  - hex(n): 0x30+n for n<10; 0x41+(n-10) for n≥10.
- STB=1 while BUSY=1: ignore it, pulse DROP for exactly one cycle, and leave the frame in progress untouched.
- FSM states:
  - IDLE → START on an accepted STB.
  - START (TX=0, one bit period) → DATA.
  - DATA (8 bits, LSB first, one bit period each) → STOP after bit 7.
  - STOP (TX=1, one bit period) → START if characters remain, otherwise IDLE.
- Character index 0..3 advances at the end of each STOP. Index 3 ending in STOP returns the FSM to IDLE.
- Baud counter counts 0..BAUD_DIV-1 and wraps. A bit ends when count = BAUD_DIV-1. The counter is cleared on entry to START from IDLE.

## Timing
- Cycle 0: STB accepted at the rising edge.
- Cycle 1 onward:
  - BUSY=1.
  - TX=0 (start bit), driven from a register with no combinational path from STB.
- Bit period is exactly BAUD_DIV cycles.
- No idle gap between characters: the next start bit begins the cycle after the previous stop bit ends.
- Frame length is 40 bit periods. BUSY falls, TX remains 1, and the FSM is in IDLE at cycle 1 + 40·BAUD_DIV.
- The first cycle with BUSY=0 accepts STB; a new start bit then appears one cycle later.
- STB on the last cycle of the final stop bit (BUSY still 1) is dropped.
- DROP is registered and asserts the cycle after the rejected STB.
- RSTN asserted mid-frame:
  - TX goes to 1 and BUSY goes to 0 immediately.
  - The partial frame is abandoned and is not resumed after release.

## Structure
- Shared package `uart_report_pkg`:
  - FSM state encoding (IDLE, START, DATA, STOP).
  - ASCII constants CR=0x0D, LF=0x0A, DIGIT0=0x30, ALPHA_A=0x41.
  - Hex-nibble-to-ASCII function.
- Sub-module `uart_tx_core`: BAUD_DIV-parameterised 8N1 shifter with a byte/valid/ready handshake.
  - The reporter's sequencer feeds it four bytes back-to-back.
  - `ready` rises in the same cycle the stop bit ends, giving zero-gap chaining.

## Test plan
Run all scenarios with BAUD_DIV=4 for simulation speed; the UART monitor samples mid-bit.
- DATA=0xA5, STB pulse → bytes 0x41, 0x35, 0x0D, 0x0A; BUSY high for exactly 160 cycles; each bit 4 cycles; DROP stays 0.
- DATA=0x00, then DATA=0xFF on the first BUSY=0 cycle → 0x30 0x30 0x0D 0x0A, then 0x46 0x46 0x0D 0x0A; exactly one idle cycle with TX=1 between frames.
- STB during the third character of an active frame → DROP high for exactly one cycle; transmitted bytes unchanged; no second frame follows.
- STB on the final stop-bit cycle → dropped (DROP=1); TX stays 1 afterwards; BUSY=0.
- RSTN pulsed low during the data bits of the second character → TX=1 and BUSY=0 within the same cycle; after release, a new STB with 0x3C yields 0x33 0x43 0x0D 0x0A cleanly.
- Sweep DATA=0x00..0xFF, each STB issued when BUSY=0 → every decoded pair of hex digits equals the latched DATA; no DROP pulses.
